im_mem_stage: RTL and testbench
===============================

IM_MEM_STAGE -- requirements
Module: im_mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: valid_in  in  1; O_in  in  32  address/ALU result; B_in  in  32  store data; mem_read_in  in  1; mem_write_in  in  1; access_size_in  in  2  (00 byte, 01 half, 10 word, 11 treated as word); load_signed_in  in  1.
REQ-004 SHALL have ports: dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4; dmem_rd  out  1; dmem_wr  out  1; dmem_ack  in  1; dmem_rdata  in  32.
REQ-005 SHALL have ports: O_out  out  32  registered copy of O_in; D_out  out  32  formatted load data; done_out  out  1  result valid for IM/IW register; stall_out  out  1  hold upstream; bus_err_out  out  1; misalign_out  out  1.

Function
REQ-006 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-007 IDLE, valid_in with no memory op: SHALL latch O_in into O_out and pulse done_out for 1 cycle next cycle; stall_out stays 0.
REQ-008 IDLE, valid_in with mem_read_in or mem_write_in: SHALL assert stall_out combinationally same cycle, register address/data/be/size/sign, and enter ACCESS.
REQ-009 Both mem_read_in and mem_write_in set: SHALL perform a write only.
REQ-010 ACCESS: SHALL hold dmem_rd or dmem_wr high and dmem_addr/wdata/be stable until dmem_ack; stall_out=1.
REQ-011 ACCESS with dmem_ack: SHALL drop dmem_rd/dmem_wr next cycle, register formatted dmem_rdata into D_out (reads only; writes leave D_out unchanged), enter RESP.
REQ-012 RESP: SHALL hold done_out=1 and stall_out=0 for exactly one cycle, then return to IDLE; a new valid_in in RESP is ignored (upstream advances on this cycle).
REQ-013 Timeout: 8-bit counter cleared on entering ACCESS; if it reaches 255 without ack, SHALL abort access, set D_out=0, pulse bus_err_out with done_out in RESP.
REQ-014 dmem_ack outside ACCESS SHALL be ignored.
REQ-015 Byte enables, little-endian: byte be=0001<<addr[1:0], wdata=B_in[7:0] replicated x4; half be=0011 (addr[1]=0) or 1100, wdata=B_in[15:0] x2; word be=1111, wdata=B_in.
REQ-016 Loads SHALL extract the addressed lane and sign-extend if load_signed_in else zero-extend to 32 bits.
REQ-017 dmem_addr SHALL carry the full address; low bits are not masked except per REQ-021.

Reset
REQ-018 rst SHALL force state=IDLE, counter=0, O_out=0, D_out=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, dmem_rd=0, dmem_wr=0, done_out=0, bus_err_out=0, misalign_out=0 at next posedge.
REQ-019 rst during ACCESS SHALL abandon the transfer; no done_out is produced for it.

Configuration
REQ-020 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip bus access, go IDLE->RESP, set D_out=0, pulse misalign_out with done_out.
REQ-021 Macro undefined: SHALL force addr[0]=0 for half and addr[1:0]=00 for word on dmem_addr; misalign_out tied 0.

Structure
REQ-022 Package im_pkg SHALL hold access-size encodings, FSM state enum, IM_TIMEOUT=255.
REQ-023 Lane extraction/extension SHALL be sub-module im_load_align (combinational).

Verification
REQ-024 Word load addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> D_out=0xDEADBEEF, done_out 1 cycle, stall_out high 4 cycles.
REQ-025 Signed byte load addr 0x103, rdata 0x80112233 -> D_out=0xFFFFFF80; unsigned -> 0x00000080.
REQ-026 Half store addr 0x202, B_in=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_wr held until ack.
REQ-027 No ack for 255 cycles -> bus_err_out=1, D_out=0, FSM IDLE; late ack ignored.
REQ-028 Word load addr 0x101: with MEM_ALIGN_CHECK_EN -> misalign_out=1, no dmem_rd; without -> dmem_addr=0x100.
REQ-029 rst asserted mid-ACCESS -> dmem_rd=0 next cycle, no done_out.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the IM memory stage.
// Contents: access-size encodings, the FSM state enum, the bus timeout limit and
// helpers that build byte enables and lane-replicated store data.
package im_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;
  localparam logic [1:0] SizeRsvd = 2'b11;  // behaves as a word access

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } im_state_e;

  localparam logic [7:0] IM_TIMEOUT = 8'd255;

  // Little-endian byte enables for a normalised size (never SizeRsvd).
  function automatic logic [3:0] im_byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SizeByte: be = 4'b0001 << lo;
      SizeHalf: be = lo[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated across all lanes so the enables alone pick the target.
  function automatic logic [31:0] im_store_data(input logic [1:0] size, input logic [31:0] b);
    logic [31:0] w;
    case (size)
      SizeByte: w = {4{b[7:0]}};
      SizeHalf: w = {2{b[15:0]}};
      default:  w = b;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/im_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane out of the
// 32-bit read word and sign- or zero-extends it to 32 bits.
// Ports:
//   rdata     in  32  raw word from data memory
//   addr_lo   in  2   low address bits of the access
//   size      in  2   normalised access size (byte/half/word)
//   is_signed in  1   sign-extend when set, zero-extend otherwise
//   data      out 32  formatted load value
module im_load_align
  import im_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SizeByte: data = {{24{is_signed & byte_lane[7]}}, byte_lane};
      SizeHalf: data = {{16{is_signed & half_lane[15]}}, half_lane};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/im_mem_stage.sv
// IM (memory) pipeline stage: issues one load/store per accepted op on a simple
// req/ack data bus, formats load data and hands a result to the IM/IW register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses (no bus cycle, misalign_out pulsed). Without it, the low address bits
// of half/word accesses are forced to zero on dmem_addr and misalign_out stays 0.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   valid_in, O_in, B_in               op valid, address/ALU result, store data
//   mem_read_in, mem_write_in          memory op request (write wins if both)
//   access_size_in, load_signed_in     00 byte, 01 half, 1x word; load sign mode
//   dmem_addr/wdata/be/rd/wr           data bus request, held until dmem_ack
//   dmem_ack, dmem_rdata               bus completion and read data
//   O_out, D_out                       registered O_in, formatted load data
//   done_out, stall_out                result valid pulse, upstream hold
//   bus_err_out, misalign_out          error pulses, coincident with done_out
module im_mem_stage
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] O_in,
  input  logic [31:0] B_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  access_size_in,
  input  logic        load_signed_in,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_rd,
  output logic        dmem_wr,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] O_out,
  output logic [31:0] D_out,
  output logic        done_out,
  output logic        stall_out,
  output logic        bus_err_out,
  output logic        misalign_out
);

  im_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] o_q, o_d;
  logic [31:0] d_q, d_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        bus_err_q, bus_err_d;
  logic        misalign_q, misalign_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;

  logic        mem_op;
  logic        reject;
  logic [1:0]  size_n;
  logic [31:0] addr_n;
  logic [31:0] load_data;

  assign mem_op = mem_read_in | mem_write_in;
  assign size_n = (access_size_in == SizeRsvd) ? SizeWord : access_size_in;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_n = O_in;
  assign reject = ((size_n == SizeHalf) && O_in[0]) ||
                  ((size_n == SizeWord) && (O_in[1:0] != 2'b00));
`else
  always_comb begin
    addr_n = O_in;
    if (size_n == SizeHalf) begin
      addr_n[0] = 1'b0;
    end else if (size_n == SizeWord) begin
      addr_n[1:0] = 2'b00;
    end
  end
  assign reject = 1'b0;
`endif

  im_load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_d        = o_q;
    d_d        = d_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    done_d     = 1'b0;
    bus_err_d  = 1'b0;
    misalign_d = 1'b0;
    stall_out  = 1'b0;

    case (state_q)
      StIdle: begin
        if (valid_in) begin
          o_d = O_in;
          if (!mem_op) begin
            done_d = 1'b1;
          end else begin
            stall_out = 1'b1;
            if (reject) begin
              state_d    = StResp;
              done_d     = 1'b1;
              misalign_d = 1'b1;
              d_d        = '0;
            end else begin
              state_d  = StAccess;
              cnt_d    = '0;
              addr_d   = addr_n;
              be_d     = im_byte_en(size_n, addr_n[1:0]);
              wdata_d  = im_store_data(size_n, B_in);
              wr_d     = mem_write_in;
              rd_d     = ~mem_write_in;  // write takes precedence over read
              size_d   = size_n;
              signed_d = load_signed_in;
            end
          end
        end
      end

      StAccess: begin
        stall_out = 1'b1;
        if (dmem_ack) begin
          state_d = StResp;
          done_d  = 1'b1;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          if (rd_q) begin
            d_d = load_data;
          end
        end else if (cnt_q == IM_TIMEOUT - 8'd1) begin
          // Counter reads k-1 on the k-th ack-less cycle: abort after 255 of them.
          state_d   = StResp;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          d_d       = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      StResp: begin
        // Upstream advances this cycle, so anything on valid_in is dropped.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      o_q        <= '0;
      d_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      size_q     <= SizeByte;
      signed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_q        <= o_d;
      d_q        <= d_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      done_q     <= done_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
    end
  end

  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign dmem_rd      = rd_q;
  assign dmem_wr      = wr_q;
  assign O_out        = o_q;
  assign D_out        = d_q;
  assign done_out     = done_q;
  assign bus_err_out  = bus_err_q;
  assign misalign_out = misalign_q;

endmodule

// File: tb/tb_im_mem_stage.sv
// Self-checking bench for im_mem_stage: directed scenarios plus randomized
// transactions compared against an arithmetic reference model of the stage.
module tb_im_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] O_in;
  logic [31:0] B_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  access_size_in;
  logic        load_signed_in;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] O_out;
  logic [31:0] D_out;
  logic        done_out;
  logic        stall_out;
  logic        bus_err_out;
  logic        misalign_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_d;

  im_mem_stage dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .O_in           (O_in),
    .B_in           (B_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .access_size_in (access_size_in),
    .load_signed_in (load_signed_in),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rd        (dmem_rd),
    .dmem_wr        (dmem_wr),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .O_out          (O_out),
    .D_out          (D_out),
    .done_out       (done_out),
    .stall_out      (stall_out),
    .bus_err_out    (bus_err_out),
    .misalign_out   (misalign_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int unsigned eff_size(input logic [1:0] s);
    return (s == 2'd3) ? 2 : int'(s);  // 0 byte, 1 half, 2 word
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [1:0] s, input bit sgn);
    int unsigned sh;
    logic [31:0] v;
    case (eff_size(s))
      0: begin
        sh = 8 * int'(a[1:0]);
        v  = (rdata >> sh) & 32'h0000_00FF;
        if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      1: begin
        sh = 16 * int'(a[1]);
        v  = (rdata >> sh) & 32'h0000_FFFF;
        if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] s);
    case (eff_size(s))
      0:       return 4'b0001 << a[1:0];
      1:       return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] b, input logic [1:0] s);
    case (eff_size(s))
      0:       return (b & 32'hFF) * 32'h0101_0101;
      1:       return (b & 32'hFFFF) * 32'h0001_0001;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [1:0] s);
`ifdef MEM_ALIGN_CHECK_EN
    return a;
`else
    case (eff_size(s))
      1:       return a & ~32'd1;
      2:       return a & ~32'd3;
      default: return a;
    endcase
`endif
  endfunction

  function automatic bit misaligned(input logic [31:0] a, input logic [1:0] s);
    return (eff_size(s) == 1 && a[0]) || (eff_size(s) == 2 && a[1:0] != 2'b00);
  endfunction

  // One transaction issued from IDLE; returns the number of cycles stall_out was high.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] o, input logic [31:0] b,
                        input logic [1:0] s, input bit sgn, input int ack_dly,
                        input logic [31:0] rdata, input bit poke_resp, input string tag,
                        output int stalls);
    bit memop;
    bit rej;
    memop  = rd | wr;
    rej    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    rej = memop && misaligned(o, s);
`endif
    stalls = 0;
    valid_in       = 1'b1;
    O_in           = o;
    B_in           = b;
    mem_read_in    = rd;
    mem_write_in   = wr;
    access_size_in = s;
    load_signed_in = sgn;
    #1;
    chk({tag, "_stall0"}, stall_out, memop);
    if (stall_out) stalls++;
    @(negedge clk);
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    chk({tag, "_oout"}, O_out, o);
    if (!memop) begin
      chk({tag, "_done"}, done_out, 1);
      chk({tag, "_stall"}, stall_out, 0);
      chk({tag, "_dout"}, D_out, model_d);
    end else if (rej) begin
      model_d = '0;
      chk({tag, "_mis_done"}, done_out, 1);
      chk({tag, "_mis_flag"}, misalign_out, 1);
      chk({tag, "_mis_nobus"}, {dmem_rd, dmem_wr}, 0);
      chk({tag, "_mis_dout"}, D_out, 0);
    end else begin
      chk({tag, "_addr"}, dmem_addr, exp_addr(o, s));
      chk({tag, "_be"}, dmem_be, exp_be(o, s));
      chk({tag, "_wdata"}, dmem_wdata, exp_wdata(b, s));
      for (int i = 1; i <= ack_dly; i++) begin
        chk({tag, "_rdwr_held"}, {dmem_rd, dmem_wr}, wr ? 2'b01 : 2'b10);
        chk({tag, "_nodone"}, done_out, 0);
        if (stall_out) stalls++;
        if (i == ack_dly) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        @(negedge clk);
      end
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (!wr) model_d = exp_load(rdata, o, s, sgn);
      chk({tag, "_done"}, done_out, 1);
      chk({tag, "_resp_stall"}, stall_out, 0);
      chk({tag, "_rdwr_drop"}, {dmem_rd, dmem_wr}, 0);
      chk({tag, "_dout"}, D_out, model_d);
      chk({tag, "_buserr"}, bus_err_out, 0);
    end
    if (poke_resp && memop) begin
      valid_in = 1'b1;
      O_in     = ~o;
    end
    @(negedge clk);
    valid_in = 1'b0;
    chk({tag, "_done_pulse"}, done_out, 0);
    chk({tag, "_mis_pulse"}, misalign_out, 0);
    if (poke_resp && memop) chk({tag, "_resp_ignore"}, O_out, o);
  endtask

  initial begin
    int stalls;
    int cnt;
    int seen;
    bit rd, wr;
    int op;
    logic [31:0] a;

    rst            = 1'b1;
    valid_in       = 1'b0;
    O_in           = '0;
    B_in           = '0;
    mem_read_in    = 1'b0;
    mem_write_in   = 1'b0;
    access_size_in = 2'b00;
    load_signed_in = 1'b0;
    dmem_ack       = 1'b0;
    dmem_rdata     = '0;
    model_d        = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_oout", O_out, 0);
    chk("rst_dout", D_out, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_flags", {dmem_rd, dmem_wr, done_out, bus_err_out, misalign_out, stall_out}, 0);

    // Pass-through op.
    do_txn(0, 0, 32'h1234_5678, 32'h0, 2'b10, 0, 0, 32'h0, 0, "noop", stalls);

    // Word load, ack on the third access cycle.
    do_txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 3, 32'hDEAD_BEEF, 1, "wload", stalls);
    chk("wload_stall_cycles", stalls, 4);
    chk("wload_const", D_out, 32'hDEAD_BEEF);

    // Byte loads from the top lane.
    do_txn(1, 0, 32'h103, 32'h0, 2'b00, 1, 2, 32'h8011_2233, 0, "sbyte", stalls);
    chk("sbyte_const", D_out, 32'hFFFF_FF80);
    do_txn(1, 0, 32'h103, 32'h0, 2'b00, 0, 1, 32'h8011_2233, 0, "ubyte", stalls);
    chk("ubyte_const", D_out, 32'h0000_0080);

    // Half store to the upper half; D_out must survive a write.
    do_txn(0, 1, 32'h202, 32'h0000_ABCD, 2'b01, 0, 4, 32'h0, 1, "hstore", stalls);
    chk("hstore_dout_kept", D_out, 32'h0000_0080);

    // Read and write together behaves as a write.
    do_txn(1, 1, 32'h44, 32'hCAFE_F00D, 2'b11, 0, 2, 32'h1, 0, "rdwr", stalls);

    // Misaligned word load.
    do_txn(1, 0, 32'h101, 32'h0, 2'b10, 0, 2, 32'h7654_3210, 0, "mis", stalls);

    // Timeout: no ack ever.
    valid_in       = 1'b1;
    mem_read_in    = 1'b1;
    access_size_in = 2'b10;
    O_in           = 32'h300;
    @(negedge clk);
    valid_in    = 1'b0;
    mem_read_in = 1'b0;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_out) begin
        seen = 1;
        break;
      end
      if (dmem_rd) cnt++;
      @(negedge clk);
    end
    model_d = '0;
    chk("tmo_seen", seen, 1);
    chk("tmo_cycles", cnt, 255);
    chk("tmo_buserr", bus_err_out, 1);
    chk("tmo_dout", D_out, 0);
    chk("tmo_rd", dmem_rd, 0);
    dmem_ack   = 1'b1;  // late ack, lands in IDLE
    dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("late_ack_done", done_out, 0);
    chk("late_ack_buserr", bus_err_out, 0);
    chk("late_ack_dout", D_out, 0);
    chk("late_ack_stall", stall_out, 0);
    do_txn(0, 0, 32'hA5A5_0001, 32'h0, 2'b00, 0, 0, 32'h0, 0, "post_tmo", stalls);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      op = $urandom_range(0, 3);
      rd = (op == 1) || (op == 3);
      wr = (op == 2) || (op == 3);
      a  = $urandom;
      do_txn(rd, wr, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)), "rand", stalls);
    end

    // Reset in the middle of an access.
    valid_in       = 1'b1;
    mem_read_in    = 1'b1;
    access_size_in = 2'b10;
    O_in           = 32'h400;
    @(negedge clk);
    valid_in    = 1'b0;
    mem_read_in = 1'b0;
    @(negedge clk);
    chk("midrst_rd_before", dmem_rd, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_d = '0;
    chk("midrst_rd", dmem_rd, 0);
    chk("midrst_oout", O_out, 0);
    chk("midrst_dout", D_out, 0);
    chk("midrst_addr", dmem_addr, 0);
    dmem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_nodone", done_out, 0);
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    chk("midrst_stall", stall_out, 0);
    do_txn(1, 0, 32'h502, 32'h0, 2'b01, 1, 1, 32'h8001_7FFF, 0, "post_rst", stalls);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
